// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS active-low 7-segment digits with enable, hex decode and blink.
// Define HEX_RAW_MODE_EN to add RAW_SEL (address 4) and per-digit raw segment registers (addresses 8+i).
module hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              address,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    waitrequest,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    blink_phase
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned HEX_W = 7 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);

  localparam logic [3:0] A_VALUE  = 4'd0;
  localparam logic [3:0] A_ENABLE = 4'd1;
  localparam logic [3:0] A_BLINK  = 4'd2;
  localparam logic [3:0] A_STATUS = 4'd3;
`ifdef HEX_RAW_MODE_EN
  localparam logic [3:0] A_RAWSEL = 4'd4;
  localparam int unsigned A_RAW0  = 8;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  state_e                  state_q;
  logic [31:0]             readdata_q;
  logic [VAL_W-1:0]        value_q, value_d;
  logic [NUM_DIGITS-1:0]   enable_q, enable_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [HEX_W-1:0]        hex_q, hex_d;
  logic [31:0]             rdata_c;
  logic                    rd_start_c;
  logic                    unused_wdata_c;
`ifdef HEX_RAW_MODE_EN
  logic [NUM_DIGITS-1:0]   raw_sel_q, raw_sel_d;
  logic [6:0]              raw_q [NUM_DIGITS];
  logic [6:0]              raw_d [NUM_DIGITS];
`endif

  // Hex digit to active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign unused_wdata_c = ^writedata;

  // A read is only accepted from IDLE and only when no write competes with it.
  assign rd_start_c  = (state_q == S_IDLE) && read && !write;
  assign waitrequest = rst_n && rd_start_c;
  assign readdata    = readdata_q;
  assign hex_out     = hex_q;
  assign blink_phase = phase_q;

  always_comb begin
    rdata_c = '0;
    case (address)
      A_VALUE:  rdata_c = 32'(value_q);
      A_ENABLE: rdata_c = 32'(enable_q);
      A_BLINK:  rdata_c = 32'(blink_q);
      A_STATUS: begin
        rdata_c[0]    = phase_q;
        rdata_c[11:8] = 4'(NUM_DIGITS);
      end
`ifdef HEX_RAW_MODE_EN
      A_RAWSEL: rdata_c = 32'(raw_sel_q);
`endif
      default: rdata_c = '0;
    endcase
`ifdef HEX_RAW_MODE_EN
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (address == 4'(A_RAW0 + i)) rdata_c = 32'(raw_q[i]);
    end
`endif
  end

  always_comb begin
    value_d  = value_q;
    enable_d = enable_q;
    blink_d  = blink_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
`ifdef HEX_RAW_MODE_EN
    raw_sel_d = raw_sel_q;
    raw_d     = raw_q;
`endif
    if (write) begin
      case (address)
        A_VALUE:  value_d  = writedata[VAL_W-1:0];
        A_ENABLE: enable_d = writedata[NUM_DIGITS-1:0];
        A_BLINK:  blink_d  = writedata[NUM_DIGITS-1:0];
`ifdef HEX_RAW_MODE_EN
        A_RAWSEL: raw_sel_d = writedata[NUM_DIGITS-1:0];
`endif
        default: ;
      endcase
`ifdef HEX_RAW_MODE_EN
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (address == 4'(A_RAW0 + i)) raw_d[i] = writedata[6:0];
      end
`endif
    end
    // Restarting the timebase on a BLINK write keeps newly blinking digits visible first.
    if (write && address == A_BLINK) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Per-digit priority: disabled, then blank-by-blink, then the selected pattern.
  always_comb begin
    hex_d = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (enable_q[i] && !(blink_q[i] && phase_q)) begin
`ifdef HEX_RAW_MODE_EN
        hex_d[7*i +: 7] = raw_sel_q[i] ? raw_q[i] : seg_decode(value_q[4*i +: 4]);
`else
        hex_d[7*i +: 7] = seg_decode(value_q[4*i +: 4]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      enable_q <= '0;
      blink_q  <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      hex_q    <= '1;
`ifdef HEX_RAW_MODE_EN
      raw_sel_q <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) raw_q[i] <= 7'h7F;
`endif
    end else begin
      value_q  <= value_d;
      enable_q <= enable_d;
      blink_q  <= blink_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      hex_q    <= hex_d;
`ifdef HEX_RAW_MODE_EN
      raw_sel_q <= raw_sel_d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) raw_q[i] <= raw_d[i];
`endif
    end
  end

  // Read FSM: capture in IDLE, present data for one RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      readdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_start_c) begin
            readdata_q <= rdata_c;
            state_q    <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed vector table, blink/reset sequences and random traffic
// checked against a cycle-level reference model of the register map and display rules.
module tb_hex_display_ctrl;

  localparam int unsigned ND  = 6;
  localparam int unsigned DIV = 4;
  localparam int unsigned HW  = 7 * ND;
  localparam logic [31:0] VMASK = (ND == 8) ? 32'hFFFF_FFFF : 32'((64'd1 << (4 * ND)) - 64'd1);
  localparam logic [31:0] DMASK = 32'((64'd1 << ND) - 64'd1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic [HW-1:0] hex_out;
  logic          blink_phase;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .hex_out(hex_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [6:0]    dec_tab [16];
  logic [31:0]   m_value, m_enable, m_blink, m_rawsel, m_rd;
  logic [6:0]    m_raw [8];
  int unsigned   m_t;
  bit            m_resp;
  logic [HW-1:0] m_hex;

  typedef struct {
    logic [3:0]  addr;
    bit          wr;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_phase();
    return ((m_t / DIV) % 2) != 0;
  endfunction

  task automatic m_reset();
    m_value = 0; m_enable = 0; m_blink = 0; m_rawsel = 0; m_rd = 0;
    for (int i = 0; i < 8; i++) m_raw[i] = 7'h7F;
    m_t = 0; m_resp = 0; m_hex = '1;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      4'd0: r = m_value;
      4'd1: r = m_enable;
      4'd2: r = m_blink;
      4'd3: begin r[0] = m_phase(); r[11:8] = 4'(ND); end
`ifdef HEX_RAW_MODE_EN
      4'd4: r = m_rawsel;
`endif
      default: ;
    endcase
`ifdef HEX_RAW_MODE_EN
    if (a >= 4'd8 && 32'(a) < 32'(8 + ND)) r = {25'b0, m_raw[a - 4'd8]};
`endif
    return r;
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [31:0] d);
    case (a)
      4'd0: m_value  = d & VMASK;
      4'd1: m_enable = d & DMASK;
      4'd2: m_blink  = d & DMASK;
`ifdef HEX_RAW_MODE_EN
      4'd4: m_rawsel = d & DMASK;
`endif
      default: ;
    endcase
`ifdef HEX_RAW_MODE_EN
    if (a >= 4'd8 && 32'(a) < 32'(8 + ND)) m_raw[a - 4'd8] = d[6:0];
`endif
  endtask

  function automatic logic [HW-1:0] m_hex_calc();
    logic [HW-1:0] h;
    h = '1;
    for (int i = 0; i < ND; i++) begin
      logic [6:0] s;
      if (!m_enable[i]) s = 7'h7F;
      else if (m_blink[i] && m_phase()) s = 7'h7F;
      else begin
        s = dec_tab[4'(m_value >> (4 * i))];
`ifdef HEX_RAW_MODE_EN
        if (m_rawsel[i]) s = m_raw[i];
`endif
      end
      h[7*i +: 7] = s;
    end
    return h;
  endfunction

  // One bus cycle: drive, check waitrequest, clock, advance model, check registered outputs.
  task automatic step(input logic [3:0] a, input bit rd, input bit wr, input logic [31:0] wd);
    logic [HW-1:0] hex_next;
    address = a; read = rd; write = wr; writedata = wd;
    #1 check("waitrequest", 64'(waitrequest), 64'(rd && !wr && !m_resp));
    @(posedge clk);
    hex_next = m_hex_calc();
    if (!m_resp && rd && !wr) begin
      m_rd   = m_read(a);
      m_resp = 1;
    end else begin
      m_resp = 0;
    end
    if (wr) m_write(a, wd);
    if (wr && a == 4'd2) m_t = 0;
    else m_t++;
    m_hex = hex_next;
    #1;
    check("readdata", 64'(readdata), 64'(m_rd));
    check("hex_out", 64'(hex_out), 64'(m_hex));
    check("blink_phase", 64'(blink_phase), 64'(m_phase()));
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    step(a, 1, 0, 0);
    check(name, 64'(readdata), 64'(exp));
    step(a, 1, 0, 0);
  endtask

  initial begin
    dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001; dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
    dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010; dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
    dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000; dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
    dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001; dec_tab[14] = 7'b0000110; dec_tab[15] = 7'b0001110;

    tbl[0]  = '{4'd0,  1'b1, 32'h1234_5678};
    tbl[1]  = '{4'd0,  1'b0, 32'h0034_5678};
    tbl[2]  = '{4'd1,  1'b1, 32'hFFFF_FFFF};
    tbl[3]  = '{4'd1,  1'b0, 32'h0000_003F};
    tbl[4]  = '{4'd7,  1'b1, 32'hDEAD_BEEF};
    tbl[5]  = '{4'd3,  1'b1, 32'hFFFF_FFFF};
    tbl[6]  = '{4'd2,  1'b1, 32'h0000_0000};
    tbl[7]  = '{4'd3,  1'b0, 32'h0000_0600};
    tbl[8]  = '{4'd7,  1'b0, 32'h0000_0000};
    tbl[9]  = '{4'd2,  1'b0, 32'h0000_0000};
    tbl[10] = '{4'd15, 1'b0, 32'h0000_0000};
    tbl[11] = '{4'd0,  1'b0, 32'h0034_5678};
    tbl[12] = '{4'd1,  1'b0, 32'h0000_003F};

    rst_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_readdata", 64'(readdata), 64'd0);
    check("rst_wait", 64'(waitrequest), 64'd0);
    check("rst_hex", 64'(hex_out), 64'(m_hex));
    check("rst_phase", 64'(blink_phase), 64'd0);
    rst_n = 1'b1;

    // Digits 0..5 show 3,C,5,A,0,0
    step(4'd1, 0, 1, 32'h3F);
    step(4'd0, 0, 1, 32'h00A5C3);
    step(4'd0, 0, 0, 0);
    check("hex_a5c3", 64'(hex_out), 64'({7'h40, 7'h40, 7'h08, 7'h12, 7'h46, 7'h30}));

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) step(tbl[i].addr, 0, 1, tbl[i].data);
      else bus_read(tbl[i].addr, tbl[i].data, $sformatf("tbl_rd%0d", i));
    end

    // Blink: visible for DIV cycles after the BLINK write, then blanked, then visible
    step(4'd0, 0, 1, 32'h8);
    step(4'd1, 0, 1, 32'h1);
    step(4'd2, 0, 1, 32'h1);
    for (int m = 1; m <= 12; m++) begin
      step(4'd0, 0, 0, 0);
      check($sformatf("blink_seq%0d", m), 64'(hex_out[6:0]),
            64'((((m - 1) / DIV) % 2) != 0 ? 7'h7F : 7'h00));
    end

    // Read and write together: write wins, no stall
    step(4'd0, 1, 1, 32'h00FE_DCBA);
    bus_read(4'd0, 32'h00FE_DCBA, "rdwr_value");

`ifdef HEX_RAW_MODE_EN
    step(4'd10, 0, 1, 32'h49);
    step(4'd4, 0, 1, 32'h04);
    step(4'd1, 0, 1, 32'h3F);
    step(4'd2, 0, 1, 32'h00);
    step(4'd0, 0, 0, 0);
    check("raw_digit2", 64'(hex_out[20:14]), 64'(7'b1001001));
    check("raw_digit0", 64'(hex_out[6:0]), 64'(dec_tab[4'hA]));
    bus_read(4'd10, 32'h49, "raw2_rd");
`else
    step(4'd10, 0, 1, 32'h49);
    step(4'd4, 0, 1, 32'h04);
    bus_read(4'd10, 32'h0, "raw2_absent");
    bus_read(4'd4, 32'h0, "rawsel_absent");
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int unsigned op;
      logic [3:0]  a;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      if (op <= 2) step(a, 0, 0, 0);
      else if (op <= 5) step(a, 0, 1, $urandom);
      else if (op <= 8) begin
        step(a, 1, 0, 0);
        step(a, 1, 0, 0);
      end else step(a, 1, 1, $urandom);
    end

    // Async reset while a read is stalled
    step(4'd0, 0, 1, 32'h0012_3456);
    step(4'd1, 0, 1, 32'h3F);
    address = 4'd0; read = 1'b1; write = 1'b0;
    #1 check("stall_wait", 64'(waitrequest), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_wait", 64'(waitrequest), 64'd0);
    check("arst_readdata", 64'(readdata), 64'd0);
    check("arst_hex", 64'(hex_out), {64{1'b0}} | {{(64-HW){1'b0}}, {HW{1'b1}}});
    check("arst_phase", 64'(blink_phase), 64'd0);
    read = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    bus_read(4'd0, 32'h0, "post_rst_value");
    bus_read(4'd1, 32'h0, "post_rst_enable");
    bus_read(4'd2, 32'h0, "post_rst_blink");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
